// File: rtl/mem_port_arbiter.sv
// Shares single-ported memory between fetch and data ports; ARB_ROUND_ROBIN_EN swaps fixed data priority for alternation.
// Ack pulses MEM_LAT+1 edges after the request is sampled; requesters stall by holding req until their ack.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       sel_d;
  logic       we_q;
  logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;  // 1 = data port won the previous grant

  always_comb begin
    grant_d = d_req;
    if (d_req && if_req) grant_d = !last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && (d_req || if_req)) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_d     <= 1'b0;
      we_q      <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || if_req) begin
            sel_d     <= grant_d;
            we_q      <= grant_d && d_we;
            cnt       <= LAT_M1;
            mem_read  <= !(grant_d && d_we);
            mem_write <= grant_d && d_we && (LAT_M1 == 4'd0);
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Memory read is combinational, so the word is valid in the last ACCESS cycle.
            if (!we_q) begin
              if (sel_d) d_rdata <= mem_rdata;
              else       if_rdata <= mem_rdata;
            end
            if (sel_d) d_ack  <= 1'b1;
            else       if_ack <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end else begin
            cnt       <= cnt - 4'd1;
            mem_write <= we_q && (cnt == 4'd1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported main memory in the RV32I pipeline. Shares the memory between the instruction-fetch port (read-only) and the data port (load/store). Grants one requester at a time and holds memory controls stable for a programmable number of cycles. Returns read data and a one-cycle acknowledge to the winner. It sits between the IF/MEM pipeline stages and `main_memory`, and is the only driver of the memory's `memRead`/`memWrite`/`addr`/`writeData`.

## Interface
- `MEM_LAT`, 1: cycles memory controls are held per access; legal range 1..15; 0 is illegal.
- `ADDR_W`, 32: address width, passed through unchanged.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_ack`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched word; held until next `if_ack`.
- `d_req`  in  1  data request; held with `d_we`/`d_addr`/`d_wdata` until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ack`  out  1  one-cycle pulse: access complete; `d_rdata` valid for loads.
- `d_rdata`  out  DATA_W  load data; unchanged by stores.
- `mem_read`  out  1  to memory `memRead`.
- `mem_write`  out  1  to memory `memWrite`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_wdata`  out  DATA_W  to memory `writeData`.
- `mem_rdata`  in  DATA_W  from memory `data` (combinational read).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE**
  - If either request is high, arbitrate.
  - Latch the winner's id, `we`, address and wdata into internal registers.
  - Load the latency counter with `MEM_LAT-1`.
  - Go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - Drive `mem_addr`/`mem_wdata` from the latched registers.
  - `mem_read` = !we for every ACCESS cycle.
  - `mem_write` = we only in the final ACCESS cycle (counter == 0), so each store commits exactly once.
  - Counter decrements each cycle.
  - At counter == 0: for loads, register `mem_rdata` into the winner's rdata register; go to DONE.
- **DONE**
  - Pulse the winner's ack for exactly one cycle, then go to IDLE.
  - A request still high in DONE is not re-sampled.
  - A request high in the following IDLE cycle is a new transaction (back-to-back allowed).
- **Arbitration:** fixed priority, data port over fetch port. Requests arriving mid-transaction wait; they are never dropped.
- **Outputs outside ACCESS:** `mem_read` = `mem_write` = 0; `mem_addr` and `mem_wdata` = 0.
- **Reset values:** all outputs 0, both rdata registers 0, counter 0, state IDLE.
- **Reset mid-operation:** the transaction is abandoned and no ack is issued.
  - A store whose `mem_write` is high at the reset edge is committed, because memory has no reset.
  - All controls are 0 in the cycle after the reset edge.
- Addresses are passed through unchanged; no alignment checks or byte-lane handling.

## Timing
- A request sampled high in IDLE at edge E0 produces:
  - ACCESS during cycles E0+1 .. E0+MEM_LAT;
  - ack high in cycle E0+MEM_LAT+1.
- Latency from request sample to ack: `MEM_LAT+1` edges.
- Throughput: one transaction per `MEM_LAT+2` cycles.
- rdata is registered and becomes valid in the same cycle the ack is high.
- `if_ack` and `d_ack` are never high in the same cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN`
  - **Defined:** adds a `last_grant` register, reset to fetch. When both requests are high in IDLE, the port not granted last wins, so the first contested grant after reset goes to data. Uncontested grants update `last_grant` as well.
  - **Undefined:** strict data-over-fetch priority; no `last_grant` register.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both requests high → all outputs 0; first grant begins the cycle after `rst` falls.
- **Fetch read, MEM_LAT=1:** memory[8]=0xDEADBEEF; `if_req`=1, `if_addr`=8 → `mem_read`=1 for 1 cycle, `if_ack` 2 cycles after the request is sampled, `if_rdata`=0xDEADBEEF.
- **Store then load, MEM_LAT=3:** store 0x12345678 to address 5 → `mem_write` high exactly 1 cycle, `d_ack` after 4 cycles, `d_rdata` unchanged. Then load from address 5 → `d_rdata`=0x12345678.
- **Contention:** both requests high in the same IDLE cycle.
  - Without the macro: data served first; fetch acked `MEM_LAT+2` cycles later.
  - With `ARB_ROUND_ROBIN_EN` and both requests held high: grants alternate D, I, D, I.
- **Back-to-back:** `d_req` held high across `d_ack` with a new address → second ACCESS starts the cycle after DONE; no duplicate access to the first address.
- **Reset mid-ACCESS:** `MEM_LAT=4` store, reset in the 2nd ACCESS cycle → no `d_ack`; memory word unchanged; controls 0 in the next cycle.
